freq_duty_gen: RTL and testbench



---
 rtl/freq_gen_pkg.sv | 26 ++
 rtl/freq_gen_div.sv | 79 +++++++
 rtl/freq_duty_gen.sv | 174 +++++++++++++++++
 tb/tb_freq_duty_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared definitions for the programmable test-clock generator.
// Holds the duty scaling constants, the divider latency for the default
// period width, and the state encoding of the configuration apply flow.
package freq_gen_pkg;

  localparam int PERIOD_W_DEF = 32;

  // Duty is an integer percentage. Larger requests clamp to DUTY_MAX.
  localparam int         DUTY_MAX     = 100;
  localparam logic [6:0] DUTY_DIVISOR = 7'd100;

  // Cycles from configuration acceptance to the high-time quotient being ready.
  localparam int DIV_LAT = PERIOD_W_DEF + 8;

  // IDLE      : generator stopped, no pending settings
  // RUN       : generating, no pending settings
  // RUN_PEND  : generating, new non-zero period waits for the period boundary
  // STOP_PEND : generating, stop request waits for the period boundary
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RUN_PEND,
    STOP_PEND
  } state_t;

endpackage

// File: rtl/freq_gen_div.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per cycle. done pulses for one cycle exactly
// STEPS+1 cycles after start is sampled, and quotient then holds until the
// next start.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (control only)
//   start     : load dividend/divisor and begin dividing
//   dividend  : DVD_W-bit unsigned numerator
//   divisor   : DSR_W-bit unsigned denominator (non-zero)
//   done      : one-cycle pulse, quotient valid
//   quotient  : low QUO_W bits of the quotient
module freq_gen_div #(
  parameter int DVD_W = 39,
  parameter int DSR_W = 7,
  parameter int QUO_W = 32,
  parameter int STEPS = DVD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int CNT_W = $clog2(STEPS + 1);

  logic             busy;
  logic [CNT_W-1:0] step;
  logic [DVD_W-1:0] quo;
  logic [DSR_W-1:0] rem;
  logic [DSR_W-1:0] dsr;
  logic [DSR_W:0]   shifted;
  logic [DSR_W+1:0] diff;

  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit into the partial remainder and one quotient bit in.
  always_comb begin
    shifted = {rem, quo[DVD_W-1]};
    diff    = {1'b0, shifted} - {2'b00, dsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      step <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        step <= '0;
      end else if (busy) begin
        if (step == CNT_W'(STEPS)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          step <= step + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
    end else if (busy && (step != CNT_W'(STEPS))) begin
      quo <= {quo[DVD_W-2:0], ~diff[DSR_W+1]};
      if (!diff[DSR_W+1]) rem <= diff[DSR_W-1:0];
      else                rem <= shifted[DSR_W-1:0];
    end
  end

  assign quotient = quo[QUO_W-1:0];

endmodule

// File: rtl/freq_duty_gen.sv
// Programmable test-clock generator.
// clk_out has a period of cfg_period sys_clk cycles and a high time of
// floor(period * duty / 100). New settings only take effect at a period
// boundary (or right away when idle), so clk_out never glitches.
// Optional feature: define FREQ_GEN_CYCLE_CNT_EN to add cyc_cnt, the count
// of completed generated periods since the last apply (saturating).
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   cfg_valid/ready  : configuration handshake
//   cfg_period       : period in sys_clk cycles, 0 stops the generator
//   cfg_duty         : duty in percent, values above 100 clamp to 100
//   cfg_err          : one-cycle pulse when a period of 1 is rejected
//   clk_out          : generated clock (registered)
//   running          : generator active
//   period_start     : pulse on the first cycle of each generated period
//   cyc_cnt          : completed periods since last apply (optional)
module freq_duty_gen
  import freq_gen_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DUTY_W   = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  output logic                cfg_err,
  output logic                clk_out,
  output logic                running,
`ifdef FREQ_GEN_CYCLE_CNT_EN
  output logic [31:0]         cyc_cnt,
`endif
  output logic                period_start
);

  localparam int PROD_W = PERIOD_W + 7;
  localparam int LAT    = DIV_LAT - PERIOD_W_DEF + PERIOD_W;

  function automatic logic [6:0] sat_duty(input logic [DUTY_W-1:0] d);
    if (d > DUTY_W'(DUTY_MAX)) return 7'(DUTY_MAX);
    return 7'(d);
  endfunction

  state_t              state, state_nxt;
  logic                accept, reject, div_start, at_end;
  logic                apply, capture, stop_now;
  logic [PERIOD_W-1:0] apply_period, apply_high;
  logic [PERIOD_W-1:0] req_period, pend_period, pend_high;
  logic [PERIOD_W-1:0] period_act, high_act, cnt;
  logic [PROD_W-1:0]   product;
  logic                div_done;
  logic [PERIOD_W-1:0] div_quo;

  assign accept    = cfg_valid && cfg_ready;
  assign reject    = accept && (cfg_period == PERIOD_W'(1));
  assign div_start = accept && !reject;
  assign at_end    = (cnt == period_act - 1'b1);
  assign product   = PROD_W'(cfg_period) * PROD_W'(sat_duty(cfg_duty));
  assign running   = (state != IDLE);

  freq_gen_div #(
    .DVD_W (PROD_W),
    .DSR_W (7),
    .QUO_W (PERIOD_W),
    .STEPS (LAT - 1)
  ) u_div (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .start    (div_start),
    .dividend (product),
    .divisor  (DUTY_DIVISOR),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // A finished divide applies at once when idle or already at the period
  // boundary; otherwise it is parked in the pending registers.
  always_comb begin
    state_nxt    = state;
    apply        = 1'b0;
    capture      = 1'b0;
    apply_period = req_period;
    apply_high   = div_quo;
    case (state)
      IDLE: begin
        if (div_done) begin
          apply     = 1'b1;
          state_nxt = (req_period != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (div_done) begin
          if (at_end) begin
            apply     = 1'b1;
            state_nxt = (req_period != '0) ? RUN : IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = (req_period != '0) ? RUN_PEND : STOP_PEND;
          end
        end
      end
      RUN_PEND, STOP_PEND: begin
        if (at_end) begin
          apply        = 1'b1;
          apply_period = pend_period;
          apply_high   = pend_high;
          state_nxt    = (state == RUN_PEND) ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    stop_now = apply && running && (apply_period == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      clk_out      <= 1'b0;
      period_start <= 1'b0;
      cnt          <= '0;
      period_act   <= '0;
      high_act     <= '0;
      req_period   <= '0;
      pend_period  <= '0;
      pend_high    <= '0;
    end else begin
      cfg_err <= reject;
      if (div_start) begin
        cfg_ready  <= 1'b0;
        req_period <= cfg_period;
      end else if (apply) begin
        cfg_ready <= 1'b1;
      end
      if (capture) begin
        pend_period <= req_period;
        pend_high   <= div_quo;
      end
      if (apply) begin
        period_act <= apply_period;
        high_act   <= apply_high;
        cnt        <= '0;
      end else if (running) begin
        cnt <= at_end ? '0 : cnt + 1'b1;
      end
      // Output stage: one cycle behind cnt; a stop silences it immediately.
      clk_out      <= running && !stop_now && (cnt < high_act);
      period_start <= running && !stop_now && (cnt == '0);
    end
  end

`ifdef FREQ_GEN_CYCLE_CNT_EN
  // The first period_start after an apply opens period one; each later one
  // closes a completed period.
  logic seen_start;
  always_ff @(posedge sys_clk) begin
    if (sys_rst || apply) begin
      cyc_cnt    <= '0;
      seen_start <= 1'b0;
    end else if (period_start) begin
      if (!seen_start)         seen_start <= 1'b1;
      else if (cyc_cnt != '1)  cyc_cnt    <= cyc_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_freq_duty_gen.sv
module tb_freq_duty_gen;
  import freq_gen_pkg::*;

  localparam int PW = 32;
  localparam int DW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [PW-1:0] cfg_period = '0;
  logic [DW-1:0] cfg_duty = '0;
  logic          cfg_ready, cfg_err, clk_out, running, period_start;
`ifdef FREQ_GEN_CYCLE_CNT_EN
  logic [31:0]   cyc_cnt;
`endif

  freq_duty_gen #(.PERIOD_W(PW), .DUTY_W(DW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_err      (cfg_err),
    .clk_out      (clk_out),
    .running      (running),
`ifdef FREQ_GEN_CYCLE_CNT_EN
    .cyc_cnt      (cyc_cnt),
`endif
    .period_start (period_start)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the waveform is a function of absolute edge number
  // relative to the edge where the active settings were applied.
  longint edge_n = 0;
  bit     m_run, m_ready, m_err, m_clk, m_ps, m_pend;
  longint m_T, m_P, m_H, m_pend_edge, m_pend_P, m_pend_H, m_ps_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge();
    bit     apply, stop_now;
    longint cnt_prev, d;
    edge_n++;
    if (sys_rst) begin
      m_run = 0; m_ready = 1; m_err = 0; m_clk = 0; m_ps = 0; m_pend = 0; m_ps_cnt = 0;
      return;
    end
    cnt_prev = m_run ? (edge_n - 1 - m_T) % m_P : 0;
    apply    = m_pend && (edge_n >= m_pend_edge) && (!m_run || cnt_prev == m_P - 1);
    stop_now = apply && m_run && (m_pend_P == 0);
    if (apply) m_ps_cnt = 0;
    else if (m_ps) m_ps_cnt++;
    m_clk = m_run && !stop_now && (cnt_prev < m_H);
    m_ps  = m_run && !stop_now && (cnt_prev == 0);
    m_err = 0;
    if (apply) begin
      m_pend = 0; m_ready = 1; m_run = (m_pend_P != 0);
      m_T = edge_n; m_P = m_pend_P; m_H = m_pend_H;
    end else if (cfg_valid && m_ready) begin
      if (cfg_period == 1) m_err = 1;
      else begin
        d = (cfg_duty > 100) ? 100 : longint'(cfg_duty);
        m_ready = 0; m_pend = 1; m_pend_edge = edge_n + DIV_LAT + 1;
        m_pend_P = longint'(cfg_period);
        m_pend_H = (m_pend_P * d) / 100;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input longint p, input int d);
    sys_rst = r; cfg_valid = v; cfg_period = p[PW-1:0]; cfg_duty = d[DW-1:0];
    model_edge();
    @(posedge sys_clk);
    #1;
    check("cfg_ready", cfg_ready, m_ready);
    check("cfg_err", cfg_err, m_err);
    check("running", running, m_run);
    check("clk_out", clk_out, m_clk);
    check("period_start", period_start, m_ps);
`ifdef FREQ_GEN_CYCLE_CNT_EN
    check("cyc_cnt", cyc_cnt, (m_ps_cnt == 0) ? 0 : m_ps_cnt - 1);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Issue one configuration: wait (bounded) for cfg_ready, then present it.
  task automatic configure(input longint p, input int d);
    int n = 0;
    while (!cfg_ready && n < 400) begin idle(1); n++; end
    check("cfg_ready_wait", cfg_ready, 1);
    step(0, 1, p, d);
  endtask

  typedef struct {
    longint period;
    int     duty;
    longint exp_high;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int     n, highs, j;

    vecs[0] = '{period: 10,  duty: 50,  exp_high: 5};
    vecs[1] = '{period: 10,  duty: 33,  exp_high: 3};
    vecs[2] = '{period: 8,   duty: 150, exp_high: 8};
    vecs[3] = '{period: 8,   duty: 0,   exp_high: 0};
    vecs[4] = '{period: 7,   duty: 99,  exp_high: 6};
    vecs[5] = '{period: 3,   duty: 67,  exp_high: 2};
    vecs[6] = '{period: 255, duty: 255, exp_high: 255};

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_clk_out", clk_out, 0);
    check("rst_running", running, 0);

    // Table: latency from idle accept to first period, high time, period length
    foreach (vecs[i]) begin
      step(1, 0, 0, 0);
      step(0, 1, vecs[i].period, vecs[i].duty);
      n = 0;
      while (!period_start && n < 300) begin idle(1); n++; end
      check("tbl_latency", n, DIV_LAT + 2);
      highs = int'(clk_out);
      j = 0;
      do begin
        idle(1);
        j++;
        if (j < vecs[i].period) highs += int'(clk_out);
      end while (!period_start && j < 600);
      check("tbl_period", j, vecs[i].period);
      check("tbl_high", highs, vecs[i].exp_high);
    end

    // Mid-period switch 10/50 -> 4/50: old period finishes, then 2/2
    step(1, 0, 0, 0);
    configure(10, 50);
    n = 0;
    while (!period_start && n < 300) begin idle(1); n++; end
    idle(3);
    configure(4, 50);
    n = 0;
    while (!cfg_ready && n < 300) begin idle(1); n++; end
    check("switch_ready", cfg_ready, 1);
    idle(20);

    // Reject period 1, then stop with period 0
    configure(1, 50);
    check("rej_err", cfg_err, 1);
    check("rej_ready", cfg_ready, 1);
    check("rej_running", running, 1);
    idle(3);
    configure(0, 0);
    n = 0;
    while (running && n < 300) begin idle(1); n++; end
    check("stop_running", running, 0);
    check("stop_clk_out", clk_out, 0);
    idle(5);

    // Stop while already idle is a no-op
    configure(0, 50);
    idle(DIV_LAT + 3);
    check("idle_stop_ready", cfg_ready, 1);
    check("idle_stop_running", running, 0);

    // Reset in the middle of a divide: nothing applies afterwards
    configure(10, 50);
    idle(10);
    step(1, 0, 0, 0);
    check("rstdiv_ready", cfg_ready, 1);
    idle(DIV_LAT + 5);
    check("rstdiv_running", running, 0);

    // Reset mid-run
    configure(6, 50);
    idle(DIV_LAT + 9);
    check("prerst_running", running, 1);
    step(1, 0, 0, 0);
    check("rstrun_running", running, 0);
    check("rstrun_clk_out", clk_out, 0);
    check("rstrun_ps", period_start, 0);

`ifdef FREQ_GEN_CYCLE_CNT_EN
    check("cyc_after_rst", cyc_cnt, 0);
    configure(5, 40);
    n = 0;
    j = 0;
    while (j < 4 && n < 400) begin idle(1); n++; if (period_start) j++; end
    idle(1);
    check("cyc_three", cyc_cnt, 3);
`endif

    // Randomized traffic against the model
    step(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      longint p;
      int     r, d;
      r = int'($urandom_range(0, 99));
      if (r < 10)      p = 0;
      else if (r < 20) p = 1;
      else             p = longint'($urandom_range(2, 16));
      d = int'($urandom_range(0, 160));
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) == 0), p, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
